// File: rtl/uart_tx_block.sv
// uart_tx_block: UART transmitter, 1 start bit, DATA_BITS data bits LSB-first, 1 stop bit.
// Optional even-parity bit between data and stop when TX_PARITY_EN is defined.
// All outputs come straight from registers; the next-state logic precomputes the
// line level for the state being entered so serial_out changes on the same edge
// as the state.
module uart_tx_block #(
   parameter int unsigned CLKS_PER_BIT = 10,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_start,
   output logic                 tx_ready,
   output logic                 tx_done,
   output logic                 serial_out
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 ser_q, ser_d;
   logic                 ready_q, ready_d;
   logic                 done_q, done_d;
`ifdef TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif
   logic                 bit_end;

   // State, counters, shift register and output registers
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         ser_q    <= 1'b1;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
`ifdef TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         ser_q    <= ser_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
`ifdef TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Next-state, counter and registered-output logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      ser_d    = ser_q;
      ready_d  = 1'b0;
      done_d   = 1'b0;
`ifdef TX_PARITY_EN
      parity_d = parity_q;
`endif
      bit_end  = (cnt_q == CNT_LAST);

      case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            ser_d   = 1'b1;
            if (tx_start) begin
               state_d  = S_START;
               shift_d  = tx_data;
`ifdef TX_PARITY_EN
               parity_d = ^tx_data;
`endif
               cnt_d    = '0;
               ser_d    = 1'b0;
               ready_d  = 1'b0;
            end
         end

         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               cnt_d   = '0;
               idx_d   = '0;
               ser_d   = shift_q[0];
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               idx_d   = idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) begin
`ifdef TX_PARITY_EN
                  state_d = S_PARITY;
                  ser_d   = parity_q;
`else
                  state_d = S_STOP;
                  ser_d   = 1'b1;
`endif
               end else begin
                  ser_d = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

`ifdef TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               cnt_d   = '0;
               ser_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif

         S_STOP: begin
            if (bit_end) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               ser_d   = 1'b1;
               ready_d = 1'b1;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ser_d   = 1'b1;
            ready_d = 1'b1;
         end
      endcase
   end

   assign serial_out = ser_q;
   assign tx_ready   = ready_q;
   assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_block.sv
// Bench for uart_tx_block: per-cycle waveform model checks plus a frame scoreboard.
// Define TX_PARITY_EN for both RTL and bench to exercise the parity build.
module tb_uart_tx_block;

   localparam int C = 10;
   localparam int D = 8;
`ifdef TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int F = (D + 2 + PAR) * C;

   logic         clk;
   logic         n_rst;
   logic [7:0]   tx_data;
   logic         tx_start;
   logic         tx_ready;
   logic         tx_done;
   logic         serial_out;

   int           total;
   int           passed;
   int           cyc;
   logic         mon_en;
   logic [7:0]   exp_q[$];
   logic [9:0]   got_q[$];

   uart_tx_block #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_ready   (tx_ready),
      .tx_done    (tx_done),
      .serial_out (serial_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected {serial_out, tx_ready, tx_done} k cycles after the accept edge
   function automatic logic [2:0] exp_line(input logic [7:0] d, input int k);
      int   b;
      logic s;
      logic r;
      logic dn;
      b = k / C;
      if (k >= F)                   s = 1'b1;
      else if (b == 0)              s = 1'b0;
      else if (b <= D)              s = d[b-1];
      else if (PAR == 1 && b == D+1) s = ^d;
      else                          s = 1'b1;
      r  = (k >= F);
      dn = (k == F);
      return {s, r, dn};
   endfunction

   // Line monitor: captures each frame by sampling mid-bit
   initial begin : monitor
      logic       prev;
      logic [7:0] got;
      logic       pb;
      logic       sb;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (mon_en && prev === 1'b1 && serial_out === 1'b0) begin
            repeat (C/2) @(negedge clk);
            for (int i = 0; i < D; i++) begin
               repeat (C) @(negedge clk);
               got[i] = serial_out;
            end
            pb = 1'b0;
            if (PAR == 1) begin
               repeat (C) @(negedge clk);
               pb = serial_out;
            end
            repeat (C) @(negedge clk);
            sb = serial_out;
            got_q.push_back({got, pb, sb});
         end
         prev = serial_out;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d passed=%0d", total, passed);
      $fatal(1);
   end

   // Wait for idle, present a byte for one accept edge; returns accept cycle
   task automatic send_byte(input logic [7:0] d, input bit push, output int e);
      int n;
      n = 0;
      @(negedge clk);
      while (tx_ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         total++;
         $display("FAIL send_wait_ready: tx_ready=%b, required 1 within 1000 cycles", tx_ready);
      end
      tx_data  = d;
      tx_start = 1'b1;
      if (push) exp_q.push_back(d);
      @(negedge clk);
      tx_start = 1'b0;
      e = cyc;
   endtask

   task automatic test_reset;
      logic [2:0] obs;
      n_rst    = 1'b0;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      obs = {serial_out, tx_ready, tx_done};
      total++;
      if (obs !== 3'b110) $display("FAIL reset_state: {ser,rdy,done}=%b required 110", obs);
      else passed++;
      n_rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         obs = {serial_out, tx_ready, tx_done};
         total++;
         if (obs !== 3'b110) $display("FAIL idle_cycle%0d: {ser,rdy,done}=%b required 110", i, obs);
         else passed++;
      end
   endtask

   task automatic test_frame_a5;
      int e;
      logic [2:0] obs;
      logic [2:0] expv;
      send_byte(8'hA5, 1'b1, e);
      for (int k = 0; k <= F + 1; k++) begin
         if (k > 0) @(negedge clk);
         obs  = {serial_out, tx_ready, tx_done};
         expv = exp_line(8'hA5, k);
         total++;
         if (obs !== expv) $display("FAIL a5_wave k=%0d: {ser,rdy,done}=%b required %b", k, obs, expv);
         else passed++;
      end
   endtask

   task automatic test_ignore_busy;
      int   e;
      logic extra;
      send_byte(8'h3C, 1'b1, e);
      extra = 1'b0;
      for (int k = 1; k <= F + 30; k++) begin
         @(negedge clk);
         tx_start = (k == 20 || k == 50);
         if (k == 35) tx_data = 8'hFF;
         if (k > F && (serial_out !== 1'b1 || tx_ready !== 1'b1)) extra = 1'b1;
      end
      tx_start = 1'b0;
      total++;
      if (extra !== 1'b0) $display("FAIL busy_no_second_frame: activity after frame=%b required 0", extra);
      else passed++;
   endtask

   task automatic test_back_to_back;
      int n;
      int e;
      int d1;
      int d2;
      d1 = -1;
      d2 = -1;
      n  = 0;
      @(negedge clk);
      while (tx_ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      tx_data  = 8'h00;
      tx_start = 1'b1;
      exp_q.push_back(8'h00);
      @(negedge clk);
      e = cyc;
      tx_data = 8'hFF;
      exp_q.push_back(8'hFF);
      for (int k = 0; k < 3 * F; k++) begin
         if (tx_done === 1'b1) begin
            if (d1 < 0) begin
               d1 = cyc;
               total++;
               if (serial_out !== 1'b1) $display("FAIL b2b_idle_high: serial_out=%b required 1", serial_out);
               else passed++;
            end else if (d2 < 0) begin
               d2 = cyc;
            end
         end
         if (d1 >= 0 && cyc == d1 + 1 && tx_start === 1'b1) begin
            total++;
            if (serial_out !== 1'b0) $display("FAIL b2b_next_start: serial_out=%b required 0", serial_out);
            else passed++;
            tx_start = 1'b0;
         end
         @(negedge clk);
      end
      tx_start = 1'b0;
      total++;
      if (d1 - e !== F) $display("FAIL b2b_first_done: latency=%0d required %0d", d1 - e, F);
      else passed++;
      total++;
      if (d2 - d1 !== F + 1) $display("FAIL b2b_done_spacing: spacing=%0d required %0d", d2 - d1, F + 1);
      else passed++;
   endtask

   task automatic test_abort;
      int         e;
      int         dn;
      logic [2:0] obs;
      logic       bad;
      mon_en = 1'b0;
      send_byte(8'h55, 1'b0, e);
      repeat (C * 5 + 3) @(negedge clk);
      n_rst = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      obs = {serial_out, tx_ready, tx_done};
      total++;
      if (obs !== 3'b110) $display("FAIL abort_state: {ser,rdy,done}=%b required 110", obs);
      else passed++;
      bad = 1'b0;
      for (int k = 0; k < F + 10; k++) begin
         @(negedge clk);
         if (tx_done !== 1'b0 || serial_out !== 1'b1) bad = 1'b1;
      end
      total++;
      if (bad !== 1'b0) $display("FAIL abort_no_done: activity after abort=%b required 0", bad);
      else passed++;
      mon_en = 1'b1;
      send_byte(8'h55, 1'b1, e);
      dn = -1;
      for (int k = 0; k < F + 20 && dn < 0; k++) begin
         if (tx_done === 1'b1) dn = cyc;
         else @(negedge clk);
      end
      total++;
      if (dn - e !== F) $display("FAIL abort_resend_done: latency=%0d required %0d", dn - e, F);
      else passed++;
   endtask

`ifdef TX_PARITY_EN
   task automatic test_parity;
      int         e;
      logic [7:0] d;
      logic [2:0] obs;
      logic [2:0] expv;
      for (int t = 0; t < 2; t++) begin
         d = (t == 0) ? 8'hA5 : 8'h07;
         send_byte(d, 1'b1, e);
         for (int k = 0; k <= F + 1; k++) begin
            if (k > 0) @(negedge clk);
            obs  = {serial_out, tx_ready, tx_done};
            expv = exp_line(d, k);
            total++;
            if (obs !== expv) $display("FAIL parity_wave d=%h k=%0d: {ser,rdy,done}=%b required %b", d, k, obs, expv);
            else passed++;
         end
      end
   endtask
`endif

   task automatic test_scoreboard;
      logic [7:0] e;
      logic [9:0] g;
      logic [9:0] want;
      repeat (F + 20) @(negedge clk);
      total++;
      if (got_q.size() !== exp_q.size())
         $display("FAIL sb_frame_count: frames=%0d required %0d", got_q.size(), exp_q.size());
      else passed++;
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         want = {e, (PAR == 1) ? ^e : 1'b0, 1'b1};
         total++;
         if (g !== want) $display("FAIL sb_frame: {data,par,stop}=%h required %h", g, want);
         else passed++;
      end
   endtask

   initial begin : main
      total    = 0;
      passed   = 0;
      cyc      = 0;
      mon_en   = 1'b1;
      n_rst    = 1'b0;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      test_reset();
      test_frame_a5();
      test_ignore_busy();
      test_back_to_back();
      test_abort();
`ifdef TX_PARITY_EN
      test_parity();
`endif
      test_scoreboard();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/uart_tx_block.md
# uart_tx_block

Serial transmitter for the lab UART link: accepts a parallel byte through a one-cycle start/ready handshake, then shifts it out as one start bit, eight data bits LSB-first, and one stop bit. Each bit lasts a fixed number of clock cycles. It is the transmit-side counterpart of the existing receive block and shares its bit-period convention. Internal bit-period and bit-index timing are built from counters of the same style as the team's flex counter.

## Interface
- CLKS_PER_BIT, 10, clock cycles per serial bit; legal range 2..1023
- DATA_BITS, 8, data bits per frame; legal range 5..8
- clk  input  1  system clock; all logic on rising edge
- n_rst  input  1  synchronous active-low reset, sampled on rising edge of clk
- tx_data  input  DATA_BITS  byte to send; sampled only on the accept edge
- tx_start  input  1  request to send tx_data; honoured only while tx_ready=1
- tx_ready  output  1  high when idle and able to accept tx_start
- tx_done  output  1  one-cycle pulse after stop bit completes
- serial_out  output  1  serial line; idles high

## Operation
- Reset (n_rst=0 at a rising edge): state IDLE, serial_out=1, tx_ready=1, tx_done=0, counters=0, shift register=0.
- States: IDLE, START, DATA, PARITY (only with TX_PARITY_EN), STOP.
- IDLE: serial_out=1, tx_ready=1. When tx_start=1 at an edge:
  - tx_data is latched into the shift register.
  - The next state is START.
- START: serial_out=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: serial_out=shift[0]. After each CLKS_PER_BIT cycles:
  - the register shifts right;
  - the bit index increments.
  - After DATA_BITS bits: go to PARITY if enabled, else STOP.
- STOP: serial_out=1 for CLKS_PER_BIT cycles. Then return to IDLE with tx_done=1 for exactly that first IDLE cycle.
- Bit-period counter:
  - runs 0..CLKS_PER_BIT-1;
  - wraps to 0 on each bit boundary;
  - is cleared on every state entry.
  - Width is $clog2(CLKS_PER_BIT).
- Bit-index counter: width $clog2(DATA_BITS+1); cleared on entry to DATA.
- tx_start while tx_ready=0: ignored, with no queueing and no effect on the frame in flight.
- tx_data changes after the accept edge: no effect on the frame.
- tx_start=1 in the tx_done cycle: accepted; the new frame begins on the next edge.
- n_rst=0 mid-frame: the frame is aborted at that edge. serial_out=1 and tx_ready=1 from the next cycle, and no tx_done pulse is generated.
- serial_out, tx_ready and tx_done are all driven directly from registers, with no combinational path from inputs.

## Timing
- Accept edge E: serial_out falls to 0 and tx_ready falls to 0, both visible after edge E.
- Start bit covers cycles E+1..E+CLKS_PER_BIT. Data bit i covers the CLKS_PER_BIT cycles starting at E+1+(i+1)*CLKS_PER_BIT.
- Frame length: (DATA_BITS+2)*CLKS_PER_BIT cycles, or +CLKS_PER_BIT with parity.
- tx_done and tx_ready both rise at edge E+frame_length. tx_done falls one edge later.
- Back-to-back throughput: minimum one idle-high cycle between the stop bit and the next start bit. The minimum period is frame_length+1 cycles.

## Configuration
- TX_PARITY_EN defined:
  - PARITY state is compiled in between DATA and STOP.
  - It drives the even-parity bit (XOR of latched data) for CLKS_PER_BIT cycles.
  - Frame grows by one bit.
- TX_PARITY_EN undefined: no parity logic or state exists, and DATA goes directly to STOP.

## Test plan
- Reset, then idle for 20 cycles with tx_start=0: serial_out=1, tx_ready=1, tx_done=0 throughout.
- CLKS_PER_BIT=10, send 0xA5:
  - serial_out is 0,1,0,1,0,0,1,0,1,1, each held 10 cycles (start, LSB-first data, stop);
  - tx_done pulses once at cycle 100 after accept.
- Send 0x3C while pulsing tx_start and changing tx_data to 0xFF at cycle 35: the transmitted data bits remain 0,0,1,1,1,1,0,0, and no second frame occurs.
- Hold tx_start=1 continuously with 0x00 then 0xFF: two frames, exactly one idle-high cycle between them, and two tx_done pulses 101 cycles apart.
- Assert n_rst=0 for one cycle during data bit 4 of 0x55: serial_out=1 and tx_ready=1 after that edge, and no tx_done pulse. A following send of 0x55 is transmitted correctly.
- TX_PARITY_EN defined:
  - 0xA5 gives parity bit 0 and 0x07 gives parity bit 1, each held 10 cycles before the stop bit;
  - frame length is 110 cycles.
